// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port-0 arbiter slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } mem_req_t;

  localparam int DMEM_WORDS = 1024;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for data-memory port 0: registered grant FSM with
// round-robin tie-breaking and a bounded burst per tenure.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_gnt,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_gnt,
  output logic [31:0] m1_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mem_req_t         sel;

  // Counter never wraps: a sole requester parks at the burst limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_TOP) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    unique case (state)
      ARB_IDLE: begin
        if (m0_req && (!m1_req || last)) begin
          state_nxt = ARB_OWN0;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (m1_req) begin
          state_nxt = ARB_OWN1;
          last_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      ARB_OWN0: begin
        if (!m0_req || (cnt == CNT_TOP && m1_req)) begin
          cnt_nxt = '0;
          if (m1_req) begin
            state_nxt = ARB_OWN1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      ARB_OWN1: begin
        if (!m1_req || (cnt == CNT_TOP && m0_req)) begin
          cnt_nxt = '0;
          if (m0_req) begin
            state_nxt = ARB_OWN0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grant and steering are combinational from the registered owner.
  always_comb begin
    m0_gnt = (state == ARB_OWN0) && m0_req;
    m1_gnt = (state == ARB_OWN1) && m1_req;
    sel    = '0;
    m0_rd  = '0;
    m1_rd  = '0;
    if (m0_gnt) begin
      sel   = '{we: m0_we, addr: m0_addr, wd: m0_wd};
      m0_rd = mem_rd;
    end else if (m1_gnt) begin
      sel   = '{we: m1_we, addr: m1_addr, wd: m1_wd};
      m1_rd = mem_rd;
    end
    mem_we   = sel.we & ~reset;
    mem_addr = sel.addr;
    mem_wd   = sel.wd;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural port-0 memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_gnt, m1_gnt, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [DMEM_WORDS];

  int n_cmp = 0;
  int n_mis = 0;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    m0_we  = 1'b0;
    m1_we  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;

    // reset held with m0 requesting
    step();
    @(negedge clk);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_we", mem_we, 0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("bubble_gnt0", m0_gnt, 0);
    step();
    @(negedge clk);
    chk("first_gnt0", m0_gnt, 1);

    // m0 writes, then hands over to m1 reading the same word
    step(); m0_we = 1'b1; m0_addr = 32'h10; m0_wd = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_wd", mem_wd, 32'hDEADBEEF);
    step(); m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b1; m1_addr = 32'h10;
    @(negedge clk);
    chk("drop_gnt0", m0_gnt, 0);
    chk("drop_gnt1", m1_gnt, 0);
    step();
    @(negedge clk);
    chk("rd_gnt1", m1_gnt, 1);
    chk("rd_m1", m1_rd, 32'hDEADBEEF);
    chk("rd_m0", m0_rd, 0);
    step(); m1_req = 1'b0;
    step();
    @(negedge clk);
    chk("idle_state", 32'(dut.state), 32'(ARB_IDLE));
    chk("idle_addr", mem_addr, 0);

    // both request from idle, m0 drops after two grants
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h10; m1_addr = 32'h20;
    @(negedge clk);
    chk("tie_bubble0", m0_gnt, 0);
    chk("tie_bubble1", m1_gnt, 0);
    step(); @(negedge clk);
    chk("tie_gnt0_a", m0_gnt, 1);
    chk("tie_gnt1_a", m1_gnt, 0);
    step(); @(negedge clk);
    chk("tie_gnt0_b", m0_gnt, 1);
    step(); m0_req = 1'b0;
    @(negedge clk);
    chk("tie_drop0", m0_gnt, 0);
    step(); @(negedge clk);
    chk("tie_gnt1", m1_gnt, 1);
    chk("tie_addr", mem_addr, 32'h20);

    // continuous contention: bursts of four, alternating
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      step(); @(negedge clk);
      chk($sformatf("burst_g0_%0d", k), m0_gnt, ((k / 4) % 2) == 0);
      chk($sformatf("burst_g1_%0d", k), m1_gnt, ((k / 4) % 2) == 1);
    end

    // sole requester keeps ownership, counter saturates
    do_reset();
    m1_req = 1'b1; m1_addr = 32'h20;
    @(negedge clk);
    chk("solo_bubble", m1_gnt, 0);
    for (int k = 0; k < 20; k++) begin
      step(); @(negedge clk);
      chk($sformatf("solo_g1_%0d", k), m1_gnt, 1);
    end
    chk("solo_cnt", 32'(dut.cnt), 3);

    // reset in the middle of an m1 write burst
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wd = 32'h11111111;
    @(negedge clk);
    chk("wb_bubble", m1_gnt, 0);
    step(); @(negedge clk);
    chk("wb_gnt1", m1_gnt, 1);
    chk("wb_we", mem_we, 1);
    step(); m1_wd = 32'hCAFEF00D; reset = 1'b1;
    @(negedge clk);
    chk("wb_rst_we", mem_we, 0);
    step(); reset = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    chk("wb_state", 32'(dut.state), 32'(ARB_IDLE));
    chk("wb_word", mem[32'h40 >> 2], 32'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
